// File: rtl/vedic_seq_mult8_pkg.sv
// rtl/vedic_seq_mult8_pkg.sv - shared types and sizes for the sequential 8x8 Vedic multiplier
//
// Purpose: state encoding, operand/product widths and multiply step count
//          shared by the interface, the top level and the bench.
// Ports:   none (package).
package vedic_seq_mult8_pkg;

  localparam int OP_W       = 8;
  localparam int PROD_W     = 16;
  localparam int STEP_COUNT = 4;
  localparam int STEP_W     = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef logic [OP_W-1:0]   operand_t;
  typedef logic [PROD_W-1:0] product_t;
  typedef logic [STEP_W-1:0] step_t;

endpackage

// File: rtl/vedic_seq_mult8_if.sv
// rtl/vedic_seq_mult8_if.sv - operand/result handshake bundle for vedic_seq_mult8
//
// Purpose: groups the operand channel (in_valid/in_ready/a/b) and the
//          result channel (out_valid/out_ready/q).
// Modports:
//   master - producer of operands and consumer of products (drives in_valid,
//            a, b, out_ready; observes in_ready, out_valid, q)
//   slave  - the multiplier (the reverse directions)
interface vedic_seq_mult8_if;
  import vedic_seq_mult8_pkg::*;

  logic     in_valid;
  logic     in_ready;
  operand_t a;
  operand_t b;
  logic     out_valid;
  logic     out_ready;
  product_t q;

  modport master (
    output in_valid,
    output a,
    output b,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  q
  );

  modport slave (
    input  in_valid,
    input  a,
    input  b,
    input  out_ready,
    output in_ready,
    output out_valid,
    output q
  );

endinterface

// File: rtl/Vedic_4bit.sv
// rtl/Vedic_4bit.sv - combinational 4x4 unsigned Vedic (Urdhva Tiryagbhyam) multiplier
//
// Purpose: 4x4 product built from four 2x2 Vedic cells and a short adder tree.
// Ports:
//   a [3:0] - multiplicand nibble
//   b [3:0] - multiplier nibble
//   q [7:0] - product a*b
module Vedic_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] q
);

  // 2x2 Vedic cell: vertical and crosswise terms combined with half adders.
  function automatic logic [3:0] vedic_2x2(input logic [1:0] x, input logic [1:0] y);
    logic t_cross0;
    logic t_cross1;
    logic t_high;
    logic c_mid;
    logic [3:0] r;
    r[0]     = x[0] & y[0];
    t_cross0 = x[1] & y[0];
    t_cross1 = x[0] & y[1];
    r[1]     = t_cross0 ^ t_cross1;
    c_mid    = t_cross0 & t_cross1;
    t_high   = x[1] & y[1];
    r[2]     = t_high ^ c_mid;
    r[3]     = t_high & c_mid;
    return r;
  endfunction

  logic [3:0] p_ll;
  logic [3:0] p_hl;
  logic [3:0] p_lh;
  logic [3:0] p_hh;
  logic [5:0] mid_sum;
  logic [3:0] top_sum;

  always_comb begin
    p_ll = vedic_2x2(a[1:0], b[1:0]);
    p_hl = vedic_2x2(a[3:2], b[1:0]);
    p_lh = vedic_2x2(a[1:0], b[3:2]);
    p_hh = vedic_2x2(a[3:2], b[3:2]);

    // Middle column: both cross products plus the upper half of the low cell.
    // Max 9+9+2 = 20, so 6 bits never overflow.
    mid_sum = {2'b00, p_hl} + {2'b00, p_lh} + {4'b0000, p_ll[3:2]};

    // Top column: max 9 + 5 = 14, fits in 4 bits.
    top_sum = p_hh + mid_sum[5:2];

    q = {top_sum, mid_sum[1:0], p_ll[1:0]};
  end

endmodule

// File: rtl/vedic_seq_mult8.sv
// rtl/vedic_seq_mult8.sv - 8x8 unsigned multiplier time-sharing one 4x4 Vedic core
//
// Purpose: accepts an operand pair, accumulates the four nibble partial
//          products over four MUL cycles (one core pass per cycle) and
//          presents the 16-bit product until the consumer takes it.
// Parameters:
//   ZERO_BYPASS - 1: a pair with a zero operand skips the MUL steps
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - vedic_seq_mult8_if.slave: in_valid/in_ready/a/b, out_valid/out_ready/q
//   busy - high whenever the FSM is not in IDLE
module vedic_seq_mult8
  import vedic_seq_mult8_pkg::*;
#(
  parameter bit ZERO_BYPASS = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  vedic_seq_mult8_if.slave         bus,
  output logic                     busy
);

  state_t   state;
  state_t   state_next;

  operand_t a_r;
  operand_t b_r;
  product_t acc;
  product_t acc_next;
  product_t addend;
  product_t q_r;
  step_t    step;

  logic [3:0] core_a;
  logic [3:0] core_b;
  logic [7:0] core_q;

  logic accept;
  logic zero_hit;
  logic last_step;
  logic in_ready_c;
  logic out_valid_c;
  logic busy_c;

  assign accept    = (state == ST_IDLE) && bus.in_valid;
  assign zero_hit  = ZERO_BYPASS && ((bus.a == '0) || (bus.b == '0));
  assign last_step = (step == step_t'(STEP_COUNT - 1));

  // ---------------------------------------------------------------- core
  // Step-selected nibble pairs; steps 1 and 2 share the same weight.
  always_comb begin
    core_a = a_r[3:0];
    core_b = b_r[3:0];
    case (step)
      2'd0: begin core_a = a_r[3:0]; core_b = b_r[3:0]; end
      2'd1: begin core_a = a_r[3:0]; core_b = b_r[7:4]; end
      2'd2: begin core_a = a_r[7:4]; core_b = b_r[3:0]; end
      default: begin core_a = a_r[7:4]; core_b = b_r[7:4]; end
    endcase
  end

  Vedic_4bit u_core (
    .a (core_a),
    .b (core_b),
    .q (core_q)
  );

  // Zero-extended core product placed at its nibble weight.
  always_comb begin
    addend = '0;
    case (step)
      2'd0:    addend = {8'h00, core_q};
      2'd1,
      2'd2:    addend = {4'h0, core_q, 4'h0};
      default: addend = {core_q, 8'h00};
    endcase
  end

  // Peak total is 0xFE01, so the 16-bit add cannot wrap.
  assign acc_next = acc + addend;

  // ----------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (bus.in_valid) begin
          state_next = zero_hit ? ST_DONE : ST_MUL;
        end
      end
      ST_MUL: begin
        if (last_step) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    busy_c      = 1'b1;
    case (state)
      ST_IDLE: begin
        in_ready_c = 1'b1;
        busy_c     = 1'b0;
      end
      ST_DONE: begin
        out_valid_c = 1'b1;
      end
      default: begin
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
      end
    endcase
  end

  // ------------------------------------------------------------ datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r  <= '0;
      b_r  <= '0;
      acc  <= '0;
      step <= '0;
      q_r  <= '0;
    end else begin
      if (accept) begin
        a_r  <= bus.a;
        b_r  <= bus.b;
        acc  <= '0;
        step <= '0;
        if (zero_hit) begin
          q_r <= '0;
        end
      end else if (state == ST_MUL) begin
        acc  <= acc_next;
        step <= step + 2'd1;
        // q is loaded only on the way into DONE so it holds its value
        // through IDLE and the next MUL run.
        if (last_step) begin
          q_r <= acc_next;
        end
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.q         = q_r;
  assign busy          = busy_c;

endmodule

// File: tb/tb_vedic_seq_mult8.sv
// tb/tb_vedic_seq_mult8.sv - directed self-checking bench for vedic_seq_mult8
module tb_vedic_seq_mult8;
  import vedic_seq_mult8_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   cyc;

  // index 0: ZERO_BYPASS=1 instance, index 1: ZERO_BYPASS=0 instance
  logic [1:0] in_valid;
  logic [1:0] out_ready;
  logic [7:0] a_in [2];
  logic [7:0] b_in [2];
  logic [1:0] ov_w;
  logic [1:0] ir_w;
  logic [1:0] busy_w;
  logic [15:0] q_w [2];

  vedic_seq_mult8_if if0 ();
  vedic_seq_mult8_if if1 ();

  assign if0.in_valid  = in_valid[0];
  assign if0.a         = a_in[0];
  assign if0.b         = b_in[0];
  assign if0.out_ready = out_ready[0];
  assign if1.in_valid  = in_valid[1];
  assign if1.a         = a_in[1];
  assign if1.b         = b_in[1];
  assign if1.out_ready = out_ready[1];

  assign ov_w = {if1.out_valid, if0.out_valid};
  assign ir_w = {if1.in_ready, if0.in_ready};
  assign q_w[0] = if0.q;
  assign q_w[1] = if1.q;

  vedic_seq_mult8 #(.ZERO_BYPASS(1'b1)) dut_byp (
    .clk  (clk),
    .rst  (rst),
    .bus  (if0.slave),
    .busy (busy_w[0])
  );

  vedic_seq_mult8 #(.ZERO_BYPASS(1'b0)) dut_full (
    .clk  (clk),
    .rst  (rst),
    .bus  (if1.slave),
    .busy (busy_w[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // One transaction on instance s with out_ready=1: returns the number of
  // cycles from accept to out_valid (-1 on timeout) and the product seen.
  task automatic run_op(input int s, input logic [7:0] av, input logic [7:0] bv,
                        output int lat, output logic [15:0] qv);
    @(negedge clk);
    a_in[s] = av;
    b_in[s] = bv;
    in_valid[s] = 1'b1;
    out_ready[s] = 1'b1;
    @(posedge clk);
    #1;
    in_valid[s] = 1'b0;
    lat = -1;
    qv = 16'hxxxx;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (ov_w[s]) begin
        lat = k;
        qv = q_w[s];
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      checks++;
      if ({ir_w[s], ov_w[s], busy_w[s]} !== 3'b100 || q_w[s] !== 16'h0000) begin
        failures++;
        $display("FAIL reset_outputs[%0d]: in_ready=%b out_valid=%b busy=%b q=%h, want 1 0 0 0000",
                 s, ir_w[s], ov_w[s], busy_w[s], q_w[s]);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int lat;
    logic [15:0] qv;
    run_op(0, 8'h0F, 8'h0F, lat, qv);
    checks++;
    if (lat !== 5) begin
      failures++;
      $display("FAIL basic_latency: got %0d want 5", lat);
    end
    checks++;
    if (qv !== 16'h00E1) begin
      failures++;
      $display("FAIL basic_q: got %h want 00e1", qv);
    end
    @(negedge clk);
    checks++;
    if (ir_w[0] !== 1'b1 || ov_w[0] !== 1'b0 || busy_w[0] !== 1'b0) begin
      failures++;
      $display("FAIL basic_idle_after: in_ready=%b out_valid=%b busy=%b want 1 0 0",
               ir_w[0], ov_w[0], busy_w[0]);
    end
  endtask

  task automatic test_vectors();
    logic [7:0]  va [5] = '{8'hFF, 8'hA5, 8'h01, 8'h10, 8'h9C};
    logic [7:0]  vb [5] = '{8'hFF, 8'h3C, 8'h80, 8'h10, 8'h01};
    logic [15:0] vq [5] = '{16'hFE01, 16'h26AC, 16'h0080, 16'h0100, 16'h009C};
    int lat;
    logic [15:0] qv;
    for (int i = 0; i < 5; i++) begin
      run_op(i % 2, va[i], vb[i], lat, qv);
      checks++;
      if (lat !== 5 || qv !== vq[i]) begin
        failures++;
        $display("FAIL vector[%0d] %h*%h: lat=%0d q=%h want lat=5 q=%h",
                 i, va[i], vb[i], lat, qv, vq[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_zero_bypass();
    int lat;
    logic [15:0] qv;
    run_op(0, 8'h00, 8'h7B, lat, qv);
    checks++;
    if (lat !== 1 || qv !== 16'h0000) begin
      failures++;
      $display("FAIL bypass_a_zero: lat=%0d q=%h want lat=1 q=0000", lat, qv);
    end
    @(negedge clk);
    run_op(0, 8'h55, 8'h00, lat, qv);
    checks++;
    if (lat !== 1 || qv !== 16'h0000) begin
      failures++;
      $display("FAIL bypass_b_zero: lat=%0d q=%h want lat=1 q=0000", lat, qv);
    end
    @(negedge clk);
    run_op(1, 8'h00, 8'h7B, lat, qv);
    checks++;
    if (lat !== 5 || qv !== 16'h0000) begin
      failures++;
      $display("FAIL no_bypass_zero: lat=%0d q=%h want lat=5 q=0000", lat, qv);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int seen;
    @(negedge clk);
    a_in[0] = 8'h12;
    b_in[0] = 8'h34;
    in_valid[0] = 1'b1;
    out_ready[0] = 1'b0;
    @(posedge clk);
    #1;
    // keep in_valid high with different data; it must be ignored
    a_in[0] = 8'h77;
    b_in[0] = 8'h77;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (ov_w[0]) begin
        seen = 1;
        break;
      end
    end
    checks++;
    if (seen != 1) begin
      failures++;
      $display("FAIL backpressure_wait: out_valid never rose");
    end
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (ov_w[0] !== 1'b1 || q_w[0] !== 16'h03A8 || ir_w[0] !== 1'b0) begin
        failures++;
        $display("FAIL backpressure_hold[%0d]: out_valid=%b q=%h in_ready=%b want 1 03a8 0",
                 k, ov_w[0], q_w[0], ir_w[0]);
      end
      @(negedge clk);
    end
    in_valid[0] = 1'b0;
    out_ready[0] = 1'b1;
    @(negedge clk);
    checks++;
    if (ir_w[0] !== 1'b1 || ov_w[0] !== 1'b0 || q_w[0] !== 16'h03A8) begin
      failures++;
      $display("FAIL backpressure_release: in_ready=%b out_valid=%b q=%h want 1 0 03a8",
               ir_w[0], ov_w[0], q_w[0]);
    end
  endtask

  task automatic test_reset_abort();
    int lat;
    int stray;
    logic [15:0] qv;
    @(negedge clk);
    a_in[0] = 8'hFF;
    b_in[0] = 8'hFF;
    in_valid[0] = 1'b1;
    out_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    repeat (3) @(negedge clk);   // now in step 2
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (ir_w[0] !== 1'b1 || ov_w[0] !== 1'b0 || busy_w[0] !== 1'b0 || q_w[0] !== 16'h0000) begin
      failures++;
      $display("FAIL abort_reset_state: in_ready=%b out_valid=%b busy=%b q=%h want 1 0 0 0000",
               ir_w[0], ov_w[0], busy_w[0], q_w[0]);
    end
    stray = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (ov_w[0] !== 1'b0) stray++;
    end
    checks++;
    if (stray != 0) begin
      failures++;
      $display("FAIL abort_no_result: out_valid seen %0d times want 0", stray);
    end
    run_op(0, 8'h02, 8'h03, lat, qv);
    checks++;
    if (lat !== 5 || qv !== 16'h0006) begin
      failures++;
      $display("FAIL abort_recover: lat=%0d q=%h want lat=5 q=0006", lat, qv);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [15:0] expq [$];
    logic [15:0] want;
    int last_acc;
    int n_acc;
    int n_done;
    last_acc = -1;
    n_acc = 0;
    n_done = 0;
    @(negedge clk);
    a_in[1] = 8'($urandom_range(0, 255));
    b_in[1] = 8'($urandom_range(0, 255));
    in_valid[1] = 1'b1;
    out_ready[1] = 1'b1;
    for (int c = 0; c < 8000 && n_done < 1000; c++) begin
      if (c != 0) @(negedge clk);
      if (ov_w[1]) begin
        want = (expq.size() != 0) ? expq.pop_front() : 16'hxxxx;
        checks++;
        if (q_w[1] !== want) begin
          failures++;
          $display("FAIL b2b_q[%0d]: got %h want %h", n_done, q_w[1], want);
        end
        n_done++;
      end
      if (ir_w[1] && in_valid[1]) begin
        expq.push_back({8'h00, a_in[1]} * {8'h00, b_in[1]});
        if (last_acc >= 0) begin
          checks++;
          if (cyc - last_acc != 6) begin
            failures++;
            $display("FAIL b2b_spacing[%0d]: got %0d want 6", n_acc, cyc - last_acc);
          end
        end
        last_acc = cyc;
        n_acc++;
      end
      @(posedge clk);
      #1;
      if (n_acc >= 1000) in_valid[1] = 1'b0;
      a_in[1] = 8'($urandom_range(0, 255));
      b_in[1] = 8'($urandom_range(0, 255));
    end
    checks++;
    if (n_done != 1000) begin
      failures++;
      $display("FAIL b2b_count: got %0d results want 1000", n_done);
    end
    in_valid[1] = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    in_valid = 2'b00;
    out_ready = 2'b00;
    a_in[0] = 8'h00;
    b_in[0] = 8'h00;
    a_in[1] = 8'h00;
    b_in[1] = 8'h00;
    test_reset();
    test_basic();
    test_vectors();
    test_zero_bypass();
    test_backpressure();
    test_reset_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vedic_seq_mult8.md
VEDIC_SEQ_MULT8 -- requirements
Module: vedic_seq_mult8

Interface
REQ-001 Parameter ZERO_BYPASS, default 1: when 1, an operand pair with a==0 or b==0 completes without running the multiply steps.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  operand pair a/b is valid.
REQ-005 in_ready  output  1  block can accept an operand pair.
REQ-006 a  input  8  multiplicand, unsigned.
REQ-007 b  input  8  multiplier, unsigned.
REQ-008 out_valid  output  1  q holds a completed product.
REQ-009 out_ready  input  1  consumer accepts q.
REQ-010 q  output  16  product a*b, unsigned.
REQ-011 busy  output  1  high in any state other than IDLE.

Function
REQ-012 The block SHALL compute the 8x8 unsigned product by time-multiplexing one 4x4 Vedic multiplier core over four partial products.
REQ-013 The state machine SHALL have the states IDLE, MUL and DONE.
REQ-014 IDLE: in_ready=1; on in_valid&&in_ready the block SHALL register a and b, clear the accumulator and step counter, and go to MUL (or DONE per REQ-019).
REQ-015 MUL SHALL run exactly 4 cycles, step 0..3, with core operands: step0 a[3:0]*b[3:0] added at shift 0; step1 a[3:0]*b[7:4] at shift 4; step2 a[7:4]*b[3:0] at shift 4; step3 a[7:4]*b[7:4] at shift 8.
REQ-016 Accumulator SHALL be 16 bits; the 8-bit core product SHALL be zero-extended before shifting; no overflow occurs (max 0xFE01).
REQ-017 After step3 the block SHALL go to DONE with q = final accumulator and out_valid=1.
REQ-018 Latency: operands accepted in cycle N give out_valid=1 in cycle N+5.
REQ-019 With ZERO_BYPASS=1 and a==0 or b==0 at acceptance, the block SHALL go straight to DONE with q=0, out_valid=1 in cycle N+1; with ZERO_BYPASS=0 the full 4-step sequence SHALL run.
REQ-020 DONE: out_valid and q SHALL stay stable until out_valid&&out_ready; the block then SHALL go to IDLE in the next cycle.
REQ-021 in_ready SHALL be 0 in MUL and DONE; a new pair is never accepted in the same cycle a result is taken. Minimum spacing between accepts is 6 cycles (2 with bypass).
REQ-022 in_valid during MUL/DONE SHALL be ignored; registered a/b SHALL not change until the next accept.
REQ-023 out_ready while out_valid=0 SHALL have no effect.
REQ-024 q SHALL hold its last value outside DONE; it is only meaningful while out_valid=1.

Reset
REQ-025 While rst=1 at a clock edge the block SHALL enter IDLE with in_ready=1, out_valid=0, busy=0, q=0, accumulator=0, step=0, and the registered operands cleared to 0.
REQ-026 Reset asserted during MUL or DONE SHALL abort the operation; no out_valid SHALL follow for the aborted pair.

Structure
REQ-027 A shared package SHALL hold the state encoding (IDLE=2'd0, MUL=2'd1, DONE=2'd2), the operand width 8, the product width 16 and the step count 4.
REQ-028 The block SHALL instantiate exactly one sub-module, Vedic_4bit, the team's existing combinational 4x4 Vedic core (a[3:0], b[3:0], q[7:0]), driven by step-selected nibble muxes.
REQ-029 The multiply datapath SHALL be combinational inside one cycle from the core inputs to the accumulator input; all other logic SHALL be registered.

Verification
REQ-030 a=0x0F, b=0x0F, out_ready=1 -> out_valid in cycle N+5, q=0x00E1, then in_ready=1 next cycle.
REQ-031 a=0xFF, b=0xFF -> q=0xFE01; a=0xA5, b=0x3C -> q=0x26AC.
REQ-032 ZERO_BYPASS=1, a=0x00, b=0x7B -> q=0x0000 in cycle N+1; ZERO_BYPASS=0 same stimulus -> q=0x0000 in cycle N+5.
REQ-033 a=0x12, b=0x34, out_ready held 0 for 10 cycles -> out_valid and q=0x03A8 stay stable, in_ready=0 throughout; out_ready=1 -> IDLE next cycle.
REQ-034 Accept a=0xFF, b=0xFF, assert rst in step 2 -> IDLE next cycle, all outputs at reset values, no out_valid; then a=0x02, b=0x03 -> q=0x0006.
REQ-035 Back-to-back random pairs with in_valid held high and out_ready=1 for 1000 transactions -> every q equals a*b from a reference model and accepts are spaced exactly 6 cycles apart.
